// File: rtl/axi4_lite_master_read_scheduler.sv
// Round-robin scheduler that shares one AXI4-Lite read channel (AR/R) among
// NUM_REQ local requesters. Only one transaction is outstanding at a time.
// Watchdogs bound the wait for arready and rvalid. An expired watchdog ends
// the transfer with a SLVERR response that is flagged by rsp_timeout.
module axi4_lite_master_read_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_DELAY_READY  = 16,
    parameter int MAX_DELAY_RVALID = 10,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]          req_prot,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         araddr,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int MAXD = (MAX_DELAY_READY > MAX_DELAY_RVALID) ? MAX_DELAY_READY : MAX_DELAY_RVALID;
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [CW-1:0] AR_LAST = CW'(MAX_DELAY_READY - 1);
    localparam logic [CW-1:0] R_LAST  = CW'(MAX_DELAY_RVALID - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q,       state_d;
    logic [CW-1:0]         cnt_q,         cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q,      araddr_d;
    logic [2:0]            arprot_q,      arprot_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;
    logic [1:0]            rsp_resp_q,    rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [GW-1:0]         grant_id_q,    grant_id_d;
    logic [GW-1:0]         last_grant_q,  last_grant_d;

    logic                  pick_found;
    logic [GW-1:0]         pick_idx;
    logic                  accept;

    // Round-robin pick: first pending requester after the last one served
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = GW'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    // A request is taken only while idle; reset suppresses the handshake
    assign accept = (state_q == S_IDLE) && pick_found && !areset;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign req_ready[gi] = accept && (pick_idx == GW'(gi));
            assign rsp_valid[gi] = (state_q == S_RESP) && (grant_id_q == GW'(gi));
        end
    endgenerate

    assign arvalid     = (state_q == S_ADDR);
    assign rready      = (state_q == S_DATA);
    assign busy        = (state_q != S_IDLE);
    assign araddr      = araddr_q;
    assign arprot      = arprot_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign grant_id    = grant_id_q;

    // Transfer sequencing and watchdogs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        araddr_d      = araddr_q;
        arprot_d      = arprot_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    araddr_d   = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    arprot_d   = req_prot[int'(pick_idx)*3 +: 3];
                    grant_id_d = pick_idx;
                    cnt_d      = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else if (cnt_q == AR_LAST) begin
                    cnt_d         = '0;
                    rsp_data_d    = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rvalid) begin
                    cnt_d         = '0;
                    rsp_data_d    = rdata;
                    rsp_resp_d    = rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (cnt_q == R_LAST) begin
                    cnt_d         = '0;
                    rsp_data_d    = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                last_grant_d = grant_id_q;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State registers; reset returns to idle with requester 0 first in line
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            araddr_q      <= '0;
            arprot_q      <= '0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= GW'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            araddr_q      <= araddr_d;
            arprot_q      <= arprot_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_read_scheduler.sv
// Self-checking bench for axi4_lite_master_read_scheduler. The slave side is
// scripted per transaction by two delays; expected grant, beat counts, latency
// and response are derived from the arbitration and watchdog rules.
module tb_axi4_lite_master_read_scheduler;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 16;
    localparam int MAXV = 10;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*3-1:0]  req_prot = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    logic [1:0]      grant_id;
    logic            busy;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = '0;
    logic            rvalid = 1'b0;
    logic            rready;

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    // Reference state: index of the requester served most recently
    int model_last = N - 1;
    logic [AW-1:0] tb_addr [N];
    logic [2:0]    tb_prot [N];

    axi4_lite_master_read_scheduler #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_DELAY_READY(MAXR), .MAX_DELAY_RVALID(MAXV)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_addr(req_addr), .req_prot(req_prot),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .grant_id(grant_id),
        .busy(busy), .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 aclk = ~aclk;

    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    task automatic pack_requests();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = tb_addr[i];
            req_prot[i*3 +: 3]   = tb_prot[i];
        end
    endtask

    task automatic randomize_requests();
        for (int i = 0; i < N; i++) begin
            tb_addr[i] = $urandom;
            tb_prot[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // One complete transfer. The slave raises arready on the (ar_dly+1)-th
    // arvalid cycle and rvalid on the (r_dly+1)-th rready cycle; a delay at or
    // beyond the watchdog bound means the handshake never happens.
    task automatic run_txn(input logic [N-1:0] mask, input bit hold,
                           input int ar_dly, input int r_dly,
                           input logic [DW-1:0] d, input logic [1:0] rr);
        int  w;
        bit  to_ar, to_all, got, bad_busy, bad_addr, bad_excl;
        int  exp_ar, exp_r, n_ar, n_r, rsp_c;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_resp;
        logic [N-1:0]  exp_rr;

        w      = model_pick(mask);
        to_ar  = (ar_dly >= MAXR);
        to_all = to_ar || (r_dly >= MAXV);
        exp_ar = to_ar ? MAXR : ar_dly + 1;
        exp_r  = to_ar ? 0 : ((r_dly >= MAXV) ? MAXV : r_dly + 1);
        exp_d    = to_all ? '0 : d;
        exp_resp = to_all ? 2'b10 : rr;
        exp_rr   = N'(1) << w;

        @(negedge aclk);
        pack_requests();
        req_valid = mask;
        #1;
        checks++;
        if (req_ready !== exp_rr || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept: req_ready=%b busy=%b, required req_ready=%b busy=0",
                     req_ready, busy, exp_rr);
        end

        n_ar = 0; n_r = 0; got = 0; rsp_c = -1;
        bad_busy = 0; bad_addr = 0; bad_excl = 0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge aclk);
            if (c == 0 && !hold) req_valid = '0;
            arready = (n_ar == ar_dly);
            rvalid  = (n_r == r_dly);
            rdata   = d;
            rresp   = rr;
            #1;
            if (busy !== 1'b1 || req_ready !== '0) bad_busy = 1;
            if (arvalid && rready) bad_excl = 1;
            if (arvalid === 1'b1) begin
                if (araddr !== tb_addr[w] || arprot !== tb_prot[w]) bad_addr = 1;
                n_ar++;
            end
            if (rready === 1'b1) n_r++;
            if (rsp_valid !== '0) begin
                got   = 1;
                rsp_c = c;
                checks++;
                if (rsp_valid !== exp_rr || grant_id !== 2'(w)) begin
                    errors++;
                    $display("FAIL rsp_target: rsp_valid=%b grant_id=%0d, required %b / %0d",
                             rsp_valid, grant_id, exp_rr, w);
                end
                checks++;
                if (rsp_data !== exp_d || rsp_resp !== exp_resp || rsp_timeout !== to_all) begin
                    errors++;
                    $display("FAIL rsp_payload: data=%h resp=%b timeout=%b, required %h / %b / %b",
                             rsp_data, rsp_resp, rsp_timeout, exp_d, exp_resp, to_all);
                end
            end
        end
        arready = 1'b0;
        rvalid  = 1'b0;

        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_missing: no rsp_valid within 80 cycles, required one pulse");
        end
        checks++;
        if (n_ar != exp_ar || n_r != exp_r || rsp_c != exp_ar + exp_r) begin
            errors++;
            $display("FAIL phase_len: arvalid=%0d rready=%0d rsp_cycle=%0d, required %0d / %0d / %0d",
                     n_ar, n_r, rsp_c, exp_ar, exp_r, exp_ar + exp_r);
        end
        checks++;
        if (bad_busy || bad_addr || bad_excl) begin
            errors++;
            $display("FAIL in_flight: busy/req_ready=%b araddr/arprot=%b ar_r_overlap=%b, required 0 0 0",
                     bad_busy, bad_addr, bad_excl);
        end

        // Response pulse lasts exactly one cycle; controller is idle again
        @(negedge aclk);
        #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_data !== exp_d || rsp_resp !== exp_resp) begin
            errors++;
            $display("FAIL after_rsp: rsp_valid=%b busy=%b data=%h resp=%b, required 0 0 %h %b",
                     rsp_valid, busy, rsp_data, rsp_resp, exp_d, exp_resp);
        end

        model_last = w;
        txn_no++;
        $display("txn %0d mask=%b grant=%0d addr=%h ar_dly=%0d r_dly=%0d data=%h resp=%b timeout=%0d",
                 txn_no, mask, w, tb_addr[w], ar_dly, r_dly, exp_d, exp_resp, to_all);
        req_valid = '0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({arvalid, rready, req_ready, rsp_valid, rsp_timeout, busy, araddr, arprot,
             rsp_data, rsp_resp, grant_id} !== '0) begin
            errors++;
            $display("FAIL %s: arvalid=%b rready=%b req_ready=%b rsp_valid=%b to=%b busy=%b araddr=%h arprot=%b data=%h resp=%b gid=%0d, required all 0",
                     name, arvalid, rready, req_ready, rsp_valid, rsp_timeout, busy,
                     araddr, arprot, rsp_data, rsp_resp, grant_id);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1;
        check_all_zero("reset_state");
        model_last = N - 1;
    endtask

    task automatic test_round_robin();
        randomize_requests();
        for (int i = 0; i < 4; i++) run_txn(4'b0111, 1'b1, 0, 0, $urandom, 2'b00);
    endtask

    task automatic test_single();
        randomize_requests();
        tb_addr[0] = 32'h0000_1000;
        run_txn(4'b0001, 1'b0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    endtask

    task automatic test_ar_timeout();
        randomize_requests();
        run_txn(4'b0010, 1'b0, 100, 0, $urandom, 2'b00);
    endtask

    task automatic test_boundary();
        randomize_requests();
        run_txn(4'b1000, 1'b0, MAXR - 1, MAXV - 1, $urandom, 2'b01);
    endtask

    task automatic test_r_timeout();
        randomize_requests();
        run_txn(4'b0100, 1'b0, 0, 100, $urandom, 2'b00);
    endtask

    task automatic test_back_to_back();
        randomize_requests();
        for (int i = 0; i < 3; i++) run_txn(4'b1111, 1'b1, 0, 0, $urandom, 2'($urandom_range(0, 3)));
    endtask

    task automatic test_reset_mid_data();
        bit seen;
        randomize_requests();
        @(negedge aclk);
        pack_requests();
        req_valid = 4'b0100;
        @(negedge aclk);
        req_valid = '0;
        arready   = 1'b1;
        @(negedge aclk);
        arready = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_data_setup: rready=%b, required 1", rready);
        end
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check_all_zero("reset_mid_data");
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            rvalid = 1'b1;
            #1;
            if (rsp_valid !== '0 || rready !== 1'b0) seen = 1;
        end
        rvalid = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_rsp: rsp_valid or rready seen after reset, required none");
        end
        model_last = N - 1;
        run_txn(4'b1111, 1'b0, 0, 0, $urandom, 2'b00);
    endtask

    task automatic test_random();
        int ar_dly, r_dly;
        for (int i = 0; i < 25; i++) begin
            randomize_requests();
            ar_dly = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3);
            r_dly  = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 12) : $urandom_range(0, 3);
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), ar_dly, r_dly,
                    $urandom, 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_ar_timeout();
        test_boundary();
        test_r_timeout();
        test_back_to_back();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
